// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle fetch/execute control sequencer. It sits between the
// instruction decoder and the datapath. It owns the memory handshake, the
// execute-step counter, the status register, and halt and fault handling.
// The decoder only has to map (IR, step) to a control word.
module cpu_sequencer #(
    parameter int CW_W     = 34,
    parameter int NS_W     = 2,
    parameter int SF_W     = 4,
    parameter int MAX_EXEC = 4,
    parameter int MW_BIT   = 19,
    parameter int RW_BIT   = 18,
    parameter int SL_BIT   = 24,
    parameter int STEP_W   = (MAX_EXEC > 1) ? $clog2(MAX_EXEC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   cw_in,
    input  logic [SF_W-1:0]   sf_in,
    input  logic              mem_ready,
    input  logic              halt_req,
    output logic [CW_W-1:0]   cw_out,
    output logic              il,
    output logic              mem_req,
    output logic [STEP_W-1:0] step,
    output logic [SF_W-1:0]   status,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Next-step encodings carried in the top NS_W bits of the control word.
    localparam logic [NS_W-1:0]   NS_END  = NS_W'(0);
    localparam logic [NS_W-1:0]   NS_NEXT = NS_W'(1);
    localparam logic [NS_W-1:0]   NS_HALT = NS_W'(2);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_EXEC - 1);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [SF_W-1:0]   status_q, status_d;
    logic              fault_q, fault_d;

    logic [CW_W-1:0]   cw_c;
    logic              il_c;
    logic              mem_req_c;
    logic [NS_W-1:0]   ns;
    logic              stall;

    assign ns    = cw_in[CW_W-1 -: NS_W];
    // A memory-writing step waits here until memory accepts the write.
    assign stall = cw_in[MW_BIT] & ~mem_ready;

    // State, step, status and fault registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            step_q   <= '0;
            status_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            status_q <= status_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state logic and the Mealy control outputs.
    always_comb begin
        // NOTE: every signal gets a default first. A path that leaves one
        // unassigned would otherwise infer a latch.
        state_d   = state_q;
        step_d    = step_q;
        status_d  = status_q;
        fault_d   = fault_q;
        cw_c      = '0;
        il_c      = 1'b0;
        mem_req_c = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req_c = 1'b1;
                step_d    = '0;
                if (mem_ready) begin
                    // A completed fetch takes priority over a halt request.
                    // The halt is taken at the next instruction boundary.
                    il_c    = 1'b1;
                    state_d = ST_EXEC;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end
            end

            ST_EXEC: begin
                cw_c      = cw_in;
                mem_req_c = cw_in[MW_BIT];
                if (stall) begin
                    // Hold everything, and keep the datapath from committing
                    // anything while memory is still busy.
                    cw_c[MW_BIT] = 1'b0;
                    cw_c[RW_BIT] = 1'b0;
                    cw_c[SL_BIT] = 1'b0;
                end else begin
                    if (cw_in[SL_BIT]) begin
                        status_d = sf_in;
                    end
                    case (ns)
                        NS_END: begin
                            step_d  = '0;
                            state_d = halt_req ? ST_HALT : ST_FETCH;
                        end
                        NS_NEXT: begin
                            if (step_q == LAST_STEP) begin
                                // The decoder asked for a step that does not
                                // exist. Flag it and abandon the instruction.
                                fault_d = 1'b1;
                                step_d  = '0;
                                state_d = ST_FETCH;
                            end else begin
                                step_d = step_q + STEP_W'(1);
                            end
                        end
                        NS_HALT: begin
                            step_d  = '0;
                            state_d = ST_HALT;
                        end
                        default: begin
                            // Repeat the current step. The decoder ends the loop.
                            step_d = step_q;
                        end
                    endcase
                end
            end

            ST_HALT: begin
                // Only reset leaves HALT.
                state_d = ST_HALT;
                step_d  = '0;
            end

            default: begin
                state_d = ST_FETCH;
                step_d  = '0;
            end
        endcase
    end

    // While reset is asserted, every output reads as zero. This includes the
    // combinational control word, so no write enable reaches the datapath.
    always_comb begin
        if (rst) begin
            cw_out  = '0;
            il      = 1'b0;
            mem_req = 1'b0;
            step    = '0;
            status  = '0;
            halted  = 1'b0;
            fault   = 1'b0;
        end else begin
            cw_out  = cw_c;
            il      = il_c;
            mem_req = mem_req_c;
            step    = step_q;
            status  = status_q;
            halted  = (state_q == ST_HALT);
            fault   = fault_q;
        end
    end

endmodule
